// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and data access.
// Runs one access at a time, raises pipeline stalls and aborts accesses that never complete.
module mem_port_arbiter #(
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned MAX_WAIT = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_valid,
   input  logic              dm_read,
   input  logic              dm_write,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              dm_done,
   output logic              err,
   output logic              stall_if,
   output logic              stall_pipe,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready
);

   localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_IF_BUSY = 3'd1;
   localparam logic [2:0] S_DM_BUSY = 3'd2;
   localparam logic [2:0] S_IF_RESP = 3'd3;
   localparam logic [2:0] S_DM_RESP = 3'd4;

   logic [2:0]        r_state, w_state_d;
   logic [CNT_W-1:0]  r_cnt, w_cnt_d;
   logic              r_last_dm, w_last_dm_d;
   logic              r_abort, w_abort_d;
   logic              r_mem_req, w_mem_req_d;
   logic              r_mem_we, w_mem_we_d;
   logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_d;
   logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_d;
   logic [DATA_W-1:0] r_if_rdata, w_if_rdata_d;
   logic [DATA_W-1:0] r_dm_rdata, w_dm_rdata_d;

   logic              w_dm_any;
   logic              w_timeout;
   logic [DATA_W-1:0] w_rd_val;

   assign w_dm_any  = dm_read | dm_write;
   assign w_timeout = (r_cnt == CNT_W'(MAX_WAIT - 1));
   // An aborted access returns zero instead of whatever the bus holds.
   assign w_rd_val  = mem_ready ? mem_rdata : '0;

   always_comb begin
      w_state_d     = r_state;
      w_cnt_d       = r_cnt;
      w_last_dm_d   = r_last_dm;
      w_abort_d     = r_abort;
      w_mem_req_d   = r_mem_req;
      w_mem_we_d    = r_mem_we;
      w_mem_addr_d  = r_mem_addr;
      w_mem_wdata_d = r_mem_wdata;
      w_if_rdata_d  = r_if_rdata;
      w_dm_rdata_d  = r_dm_rdata;
      case (r_state)
         S_IDLE: begin
            // Data wins unless a fetch is waiting right after a data access.
            if (w_dm_any && !(if_req && r_last_dm)) begin
               w_state_d     = S_DM_BUSY;
               w_last_dm_d   = 1'b1;
               w_mem_req_d   = 1'b1;
               w_mem_we_d    = dm_write;
               w_mem_addr_d  = dm_addr;
               w_mem_wdata_d = dm_wdata;
               w_cnt_d       = '0;
               w_abort_d     = 1'b0;
            end else if (if_req) begin
               w_state_d     = S_IF_BUSY;
               w_last_dm_d   = 1'b0;
               w_mem_req_d   = 1'b1;
               w_mem_we_d    = 1'b0;
               w_mem_addr_d  = if_addr;
               w_mem_wdata_d = '0;
               w_cnt_d       = '0;
               w_abort_d     = 1'b0;
            end
         end
         S_IF_BUSY, S_DM_BUSY: begin
            if (mem_ready || w_timeout) begin
               w_mem_req_d = 1'b0;
               w_abort_d   = ~mem_ready;
               if (r_state == S_IF_BUSY) begin
                  w_state_d    = S_IF_RESP;
                  w_if_rdata_d = w_rd_val;
               end else begin
                  w_state_d = S_DM_RESP;
                  if (!r_mem_we) begin
                     w_dm_rdata_d = w_rd_val;
                  end
               end
            end else begin
               w_cnt_d = r_cnt + CNT_W'(1);
            end
         end
         S_IF_RESP, S_DM_RESP: w_state_d = S_IDLE;
         default:              w_state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_last_dm   <= 1'b0;
         r_abort     <= 1'b0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_if_rdata  <= '0;
         r_dm_rdata  <= '0;
      end else begin
         r_state     <= w_state_d;
         r_cnt       <= w_cnt_d;
         r_last_dm   <= w_last_dm_d;
         r_abort     <= w_abort_d;
         r_mem_req   <= w_mem_req_d;
         r_mem_we    <= w_mem_we_d;
         r_mem_addr  <= w_mem_addr_d;
         r_mem_wdata <= w_mem_wdata_d;
         r_if_rdata  <= w_if_rdata_d;
         r_dm_rdata  <= w_dm_rdata_d;
      end
   end

   assign if_valid   = (r_state == S_IF_RESP);
   assign dm_done    = (r_state == S_DM_RESP);
   assign err        = (if_valid | dm_done) & r_abort;
   assign if_rdata   = r_if_rdata;
   assign dm_rdata   = r_dm_rdata;
   assign mem_req    = r_mem_req;
   assign mem_we     = r_mem_we;
   assign mem_addr   = r_mem_addr;
   assign mem_wdata  = r_mem_wdata;
   assign stall_pipe = w_dm_any & ~dm_done;
   assign stall_if   = stall_pipe | (if_req & ~if_valid);

endmodule
